// File: rtl/byte_2_word.sv
// Packs two consecutive received UART bytes into one 16-bit word.
// An inter-byte timeout drops a stranded first byte so pairing re-synchronises.
module byte_2_word #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        clr_i,
    input  logic        byte_dv_i,
    input  logic [7:0]  byte_i,
    output logic        word_dv_o,
    output logic [15:0] word_o,
    output logic        frame_err_o,
    output logic        state_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [15:0]   word_q, word_d;
    logic          word_dv_q, word_dv_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            word_q      <= '0;
            word_dv_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            word_q      <= word_d;
            word_dv_q   <= word_dv_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Strobes default to 0 every cycle, so ce=0 cannot stretch them.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        word_d      = word_q;
        word_dv_d   = 1'b0;
        frame_err_d = 1'b0;
        if (clr_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ce_i) begin
            case (state_q)
                IDLE: begin
                    if (byte_dv_i) begin
                        hold_d  = byte_i;
                        cnt_d   = '0;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    // A second byte on the timeout cycle still completes the word.
                    if (byte_dv_i) begin
                        word_d    = LSB_FIRST ? {byte_i, hold_q} : {hold_q, byte_i};
                        word_dv_d = 1'b1;
                        state_d   = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign word_dv_o   = word_dv_q;
    assign word_o      = word_q;
    assign frame_err_o = frame_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_byte_2_word.sv
// Directed bench for byte_2_word: two instances (LSB-first and MSB-first), TIMEOUT=8.
module tb_byte_2_word;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        clr = 1'b0;
    logic        byte_dv = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        l_word_dv, l_frame_err, l_state;
    logic [15:0] l_word;
    logic        m_word_dv, m_frame_err, m_state;
    logic [15:0] m_word;

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    byte_2_word #(.LSB_FIRST(1'b1), .TIMEOUT(8)) dut_lsb (
        .clk(clk), .rst(rst), .ce_i(ce), .clr_i(clr), .byte_dv_i(byte_dv),
        .byte_i(byte_in), .word_dv_o(l_word_dv), .word_o(l_word),
        .frame_err_o(l_frame_err), .state_o(l_state)
    );

    byte_2_word #(.LSB_FIRST(1'b0), .TIMEOUT(8)) dut_msb (
        .clk(clk), .rst(rst), .ce_i(ce), .clr_i(clr), .byte_dv_i(byte_dv),
        .byte_i(byte_in), .word_dv_o(m_word_dv), .word_o(m_word),
        .frame_err_o(m_frame_err), .state_o(m_state)
    );

    always @(negedge clk) begin
        if (l_word_dv && l_frame_err) overlap++;
        if (m_word_dv && m_frame_err) overlap++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_dv = 1'b1;
        byte_in = b;
        tick();
        byte_dv = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        tests++;
        if ({l_word_dv, l_frame_err, l_state, l_word} !== 19'h0) begin
            fails++;
            $display("FAIL reset_lsb: got dv=%b fe=%b st=%b word=%h expected all 0",
                     l_word_dv, l_frame_err, l_state, l_word);
        end
        tests++;
        if ({m_word_dv, m_frame_err, m_state, m_word} !== 19'h0) begin
            fails++;
            $display("FAIL reset_msb: got dv=%b fe=%b st=%b word=%h expected all 0",
                     m_word_dv, m_frame_err, m_state, m_word);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        send_byte(8'h34);
        tick();
        tick();
        tests++;
        if (l_word_dv !== 1'b0 || l_state !== 1'b1) begin
            fails++;
            $display("FAIL basic_half: got dv=%b st=%b expected dv=0 st=1", l_word_dv, l_state);
        end
        send_byte(8'h12);
        tests++;
        if (l_word_dv !== 1'b1 || l_word !== 16'h1234 || l_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL basic_word: got dv=%b word=%h fe=%b expected dv=1 word=1234 fe=0",
                     l_word_dv, l_word, l_frame_err);
        end
        tick();
        tests++;
        if (l_word_dv !== 1'b0 || l_word !== 16'h1234) begin
            fails++;
            $display("FAIL basic_pulse: got dv=%b word=%h expected dv=0 word=1234", l_word_dv, l_word);
        end
    endtask

    task automatic test_byte_order;
        send_byte(8'hAB);
        send_byte(8'hCD);
        tests++;
        if (m_word_dv !== 1'b1 || m_word !== 16'hABCD) begin
            fails++;
            $display("FAIL order_msb: got dv=%b word=%h expected dv=1 word=abcd", m_word_dv, m_word);
        end
        tests++;
        if (l_word !== 16'hCDAB) begin
            fails++;
            $display("FAIL order_lsb: got word=%h expected cdab", l_word);
        end
        tick();
        tests++;
        if (m_word_dv !== 1'b0) begin
            fails++;
            $display("FAIL order_pulse: got dv=%b expected 0", m_word_dv);
        end
    endtask

    task automatic test_timeout;
        int bad;
        send_byte(8'h55);
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (l_frame_err !== (i == 8)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL timeout_pulse: got %0d cycles with wrong frame_err expected 0", bad);
        end
        tests++;
        if (l_word !== 16'hCDAB || l_state !== 1'b0) begin
            fails++;
            $display("FAIL timeout_word: got word=%h st=%b expected word=cdab st=0", l_word, l_state);
        end
        tick();
        tests++;
        if (l_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_width: got fe=%b expected 0", l_frame_err);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        tests++;
        if (l_word_dv !== 1'b1 || l_word !== 16'h0201) begin
            fails++;
            $display("FAIL timeout_follow: got dv=%b word=%h expected dv=1 word=0201", l_word_dv, l_word);
        end
        tick();
    endtask

    task automatic test_boundary;
        int bad;
        send_byte(8'h66);
        bad = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (l_frame_err !== 1'b0) bad++;
        end
        send_byte(8'h77);
        tests++;
        if (bad != 0 || l_word_dv !== 1'b1 || l_word !== 16'h7766 || l_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL boundary_ok: got bad=%0d dv=%b word=%h fe=%b expected 0 1 7766 0",
                     bad, l_word_dv, l_word, l_frame_err);
        end
        tick();
        send_byte(8'h88);
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (l_frame_err !== (i == 8)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL boundary_late_fe: got %0d cycles with wrong frame_err expected 0", bad);
        end
        send_byte(8'h99);
        tests++;
        if (l_word_dv !== 1'b0 || l_state !== 1'b1 || l_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL boundary_new_first: got dv=%b st=%b fe=%b expected 0 1 0",
                     l_word_dv, l_state, l_frame_err);
        end
        send_byte(8'h3C);
        tests++;
        if (l_word_dv !== 1'b1 || l_word !== 16'h3C99) begin
            fails++;
            $display("FAIL boundary_late_word: got dv=%b word=%h expected dv=1 word=3c99", l_word_dv, l_word);
        end
        tick();
    endtask

    task automatic test_ce_gating;
        int bad;
        send_byte(8'h10);
        ce = 1'b0;
        byte_dv = 1'b1;
        byte_in = 8'hFF;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (l_frame_err !== 1'b0 || l_word_dv !== 1'b0 || l_state !== 1'b1) bad++;
        end
        byte_dv = 1'b0;
        ce = 1'b1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ce_hold: got %0d bad cycles expected 0", bad);
        end
        send_byte(8'h20);
        tests++;
        if (l_word_dv !== 1'b1 || l_word !== 16'h2010 || l_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL ce_word: got dv=%b word=%h fe=%b expected dv=1 word=2010 fe=0",
                     l_word_dv, l_word, l_frame_err);
        end
        ce = 1'b0;
        tick();
        tests++;
        if (l_word_dv !== 1'b0 || l_word !== 16'h2010) begin
            fails++;
            $display("FAIL ce_pulse_drop: got dv=%b word=%h expected dv=0 word=2010", l_word_dv, l_word);
        end
        ce = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        send_byte(8'h11);
        send_byte(8'h22);
        tests++;
        if (l_word_dv !== 1'b1 || l_word !== 16'h2211) begin
            fails++;
            $display("FAIL b2b_first: got dv=%b word=%h expected dv=1 word=2211", l_word_dv, l_word);
        end
        send_byte(8'h33);
        tests++;
        if (l_word_dv !== 1'b0 || l_state !== 1'b1 || l_word !== 16'h2211) begin
            fails++;
            $display("FAIL b2b_mid: got dv=%b st=%b word=%h expected 0 1 2211", l_word_dv, l_state, l_word);
        end
        send_byte(8'h44);
        tests++;
        if (l_word_dv !== 1'b1 || l_word !== 16'h4433) begin
            fails++;
            $display("FAIL b2b_second: got dv=%b word=%h expected dv=1 word=4433", l_word_dv, l_word);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int bad;
        send_byte(8'h99);
        rst = 1'b1;
        #1;
        tests++;
        if ({l_word_dv, l_frame_err, l_state, l_word} !== 19'h0) begin
            fails++;
            $display("FAIL rst_async: got dv=%b fe=%b st=%b word=%h expected all 0",
                     l_word_dv, l_frame_err, l_state, l_word);
        end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (l_frame_err !== 1'b0 || l_word_dv !== 1'b0) bad++;
        end
        send_byte(8'hAA);
        send_byte(8'hBB);
        tests++;
        if (bad != 0 || l_word_dv !== 1'b1 || l_word !== 16'hBBAA) begin
            fails++;
            $display("FAIL rst_mid_word: got bad=%0d dv=%b word=%h expected 0 1 bbaa", bad, l_word_dv, l_word);
        end
        tick();
    endtask

    task automatic test_clr_mid;
        int bad;
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h99);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tests++;
        if (l_state !== 1'b0 || l_word_dv !== 1'b0 || l_frame_err !== 1'b0 || l_word !== 16'h5544) begin
            fails++;
            $display("FAIL clr_abort: got st=%b dv=%b fe=%b word=%h expected 0 0 0 5544",
                     l_state, l_word_dv, l_frame_err, l_word);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (l_frame_err !== 1'b0 || l_word_dv !== 1'b0) bad++;
        end
        send_byte(8'hAA);
        send_byte(8'hBB);
        tests++;
        if (bad != 0 || l_word_dv !== 1'b1 || l_word !== 16'hBBAA) begin
            fails++;
            $display("FAIL clr_mid_word: got bad=%0d dv=%b word=%h expected 0 1 bbaa", bad, l_word_dv, l_word);
        end
        clr = 1'b1;
        send_byte(8'h5A);
        clr = 1'b0;
        tests++;
        if (l_state !== 1'b0 || l_word_dv !== 1'b0 || l_word !== 16'hBBAA) begin
            fails++;
            $display("FAIL clr_drops_byte: got st=%b dv=%b word=%h expected 0 0 bbaa",
                     l_state, l_word_dv, l_word);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_order();
        test_timeout();
        test_boundary();
        test_ce_gating();
        test_back_to_back();
        test_reset_mid();
        test_clr_mid();
        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL strobe_overlap: got %0d overlapping cycles expected 0", overlap);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
